// File: rtl/endian_pkg.sv
// Endianness helpers shared across the test environment.
package endian_pkg;

  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/eth_pkg.sv
// Shared types and constants for the 10G MAC TX sink: FSM states, frame_err bit
// positions, default frame-length limits and the tkeep byte-count helper.
package eth_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    GAP  = 2'd2
  } state_e;

  // frame_err = {abort, keep_err, runt, oversize}
  localparam int ERR_OVERSIZE = 0;
  localparam int ERR_RUNT     = 1;
  localparam int ERR_KEEP     = 2;
  localparam int ERR_ABORT    = 3;

  localparam int DEF_MIN_FRAME_BYTES = 60;
  localparam int DEF_MAX_FRAME_BYTES = 1518;

  // Bytes 12/13 exist only once the frame reaches 14 bytes.
  localparam logic [15:0] ETYPE_MIN_BYTES = 16'd14;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Byte count of a last-beat tkeep; 0 unless the ones are contiguous from lane 0.
  function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
    logic [8:0] inc;
    logic [3:0] n;
    inc = {1'b0, keep} + 9'd1;
    n   = '0;
    if (keep != '0 && ({1'b0, keep} & inc) == '0) begin
      for (int i = 0; i < 8; i++) n = n + {3'd0, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/eth_crc32_64.sv
// Reflected IEEE 802.3 CRC-32 update over the kept lanes of one 64-bit beat, lane 0 first.
module eth_crc32_64
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [7:0]  keep,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int l = 0; l < 8; l++) begin
      if (keep[l]) begin
        c = c ^ {24'd0, data[8*l +: 8]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_tx_sink.sv
// eth_tx_sink: TX AXI-Stream sink for the 10G MAC bench; throttles tready with an
// inter-frame gap and reports per-frame length/flags. ETH_TX_SINK_CRC_EN adds frame_crc.
module eth_tx_sink
  import eth_pkg::*;
  import endian_pkg::*;
#(
  parameter int GAP_CYCLES      = 2,
  parameter int MIN_FRAME_BYTES = DEF_MIN_FRAME_BYTES,
  parameter int MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES
) (
  input  logic                  eth_clk,
  input  logic                  sys_rst,
  input  logic                  s_axis_tx_tvalid,
  input  logic [DATA_W-1:0]     s_axis_tx_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tx_tkeep,
  input  logic                  s_axis_tx_tlast,
  input  logic                  s_axis_tx_tuser,
  output logic                  s_axis_tx_tready,
  output logic                  frame_valid,
  output logic [15:0]           frame_len,
  output logic [3:0]            frame_err,
  output logic [31:0]           frame_count,
  output logic [63:0]           first_beat,
  output logic [15:0]           ethertype
`ifdef ETH_TX_SINK_CRC_EN
  ,
  output logic [31:0]           frame_crc
`endif
);

  state_e      state_q, state_d;
  logic        tready_q, tready_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] len_q, len_d;
  logic        kerr_q, kerr_d;
  logic [1:0]  beat_q, beat_d;
  logic [63:0] first_q, first_d;
  logic [15:0] etype_q, etype_d;

  logic        fv_q, fv_d;
  logic [15:0] flen_q, flen_d;
  logic [3:0]  ferr_q, ferr_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic [63:0] fbeat_q, fbeat_d;
  logic [15:0] fet_q, fet_d;

  logic        xfer;
  logic        in_frame;
  logic [3:0]  last_bytes;
  logic [16:0] sum;
  logic [15:0] len_sat;
  logic        beat_kerr;
  logic        kerr_all;

  assign xfer     = s_axis_tx_tvalid & tready_q;
  assign in_frame = (state_q == RECV);

  always_comb begin
    last_bytes = keep_bytes(s_axis_tx_tkeep);
    sum        = {1'b0, (in_frame ? len_q : 16'd0)}
               + (s_axis_tx_tlast ? {13'd0, last_bytes} : 17'd8);
    len_sat    = sum[16] ? 16'hFFFF : sum[15:0];
    beat_kerr  = s_axis_tx_tlast ? (last_bytes == 4'd0) : (s_axis_tx_tkeep != 8'hFF);
    kerr_all   = (in_frame & kerr_q) | beat_kerr;

    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    len_d     = len_q;
    kerr_d    = kerr_q;
    beat_d    = beat_q;
    first_d   = first_q;
    etype_d   = etype_q;
    fv_d      = 1'b0;
    flen_d    = flen_q;
    ferr_d    = ferr_q;
    fcnt_d    = fcnt_q;
    fbeat_d   = fbeat_q;
    fet_d     = fet_q;

    case (state_q)
      IDLE, RECV: begin
        if (xfer) begin
          len_d  = len_sat;
          kerr_d = kerr_all;
          beat_d = !in_frame ? 2'd1 : ((beat_q == 2'd2) ? 2'd2 : beat_q + 2'd1);
          if (!in_frame) first_d = bswap64(s_axis_tx_tdata);
          if (in_frame && beat_q == 2'd1)
            etype_d = {s_axis_tx_tdata[39:32], s_axis_tx_tdata[47:40]};
          state_d = RECV;
          if (s_axis_tx_tlast) begin
            fv_d                   = 1'b1;
            flen_d                 = len_sat;
            ferr_d[ERR_ABORT]      = s_axis_tx_tuser;
            ferr_d[ERR_KEEP]       = kerr_all;
            ferr_d[ERR_RUNT]       = len_sat < 16'(MIN_FRAME_BYTES);
            ferr_d[ERR_OVERSIZE]   = len_sat > 16'(MAX_FRAME_BYTES);
            fcnt_d                 = fcnt_q + 32'd1;
            fbeat_d                = first_d;
            // A frame ending on beat 0 or 1 may be shorter than the ethertype field.
            fet_d                  = (len_sat >= ETYPE_MIN_BYTES) ? etype_d : 16'd0;
            if (GAP_CYCLES > 0) begin
              state_d   = GAP;
              gap_cnt_d = 16'(GAP_CYCLES - 1);
            end else begin
              state_d   = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'd0) state_d = IDLE;
        else                    gap_cnt_d = gap_cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    tready_d = (state_d != GAP);
  end

  // control and reported results
  always_ff @(posedge eth_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      tready_q  <= 1'b0;
      gap_cnt_q <= '0;
      fv_q      <= 1'b0;
      flen_q    <= '0;
      ferr_q    <= '0;
      fcnt_q    <= '0;
      fbeat_q   <= '0;
      fet_q     <= '0;
    end else begin
      state_q   <= state_d;
      tready_q  <= tready_d;
      gap_cnt_q <= gap_cnt_d;
      fv_q      <= fv_d;
      flen_q    <= flen_d;
      ferr_q    <= ferr_d;
      fcnt_q    <= fcnt_d;
      fbeat_q   <= fbeat_d;
      fet_q     <= fet_d;
    end
  end

  // per-frame accumulators, rebased on the first beat of every frame
  always_ff @(posedge eth_clk) begin
    len_q   <= len_d;
    kerr_q  <= kerr_d;
    beat_q  <= beat_d;
    first_q <= first_d;
    etype_q <= etype_d;
  end

  assign s_axis_tx_tready = tready_q;
  assign frame_valid      = fv_q;
  assign frame_len        = flen_q;
  assign frame_err        = ferr_q;
  assign frame_count      = fcnt_q;
  assign first_beat       = fbeat_q;
  assign ethertype        = fet_q;

`ifdef ETH_TX_SINK_CRC_EN
  logic [31:0] crc_q, crc_d, crc_base, crc_next, fcrc_q, fcrc_d;

  assign crc_base = in_frame ? crc_q : CRC_INIT;

  eth_crc32_64 u_crc (
    .crc_in  (crc_base),
    .data    (s_axis_tx_tdata),
    .keep    (s_axis_tx_tkeep),
    .crc_out (crc_next)
  );

  always_comb begin
    crc_d  = xfer ? crc_next : crc_q;
    fcrc_d = (xfer && s_axis_tx_tlast) ? ~crc_next : fcrc_q;
  end

  always_ff @(posedge eth_clk) begin
    crc_q <= crc_d;
    if (sys_rst) fcrc_q <= '0;
    else         fcrc_q <= fcrc_d;
  end

  assign frame_crc = fcrc_q;
`endif

endmodule

// File: tb/tb_eth_tx_sink.sv
// Directed bench for eth_tx_sink with a scoreboard of expected frame reports;
// define ETH_TX_SINK_CRC_EN to include the CRC port and its check.
module tb_eth_tx_sink;

  logic        eth_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tvalid  = 1'b0;
  logic [63:0] tdata   = '0;
  logic [7:0]  tkeep   = '0;
  logic        tlast   = 1'b0;
  logic        tuser   = 1'b0;
  logic        tready;
  logic        frame_valid;
  logic [15:0] frame_len;
  logic [3:0]  frame_err;
  logic [31:0] frame_count;
  logic [63:0] first_beat;
  logic [15:0] ethertype;
`ifdef ETH_TX_SINK_CRC_EN
  logic [31:0] frame_crc;
`endif

  eth_tx_sink #(.GAP_CYCLES(2), .MIN_FRAME_BYTES(60), .MAX_FRAME_BYTES(1518)) dut (
    .eth_clk          (eth_clk),
    .sys_rst          (sys_rst),
    .s_axis_tx_tvalid (tvalid),
    .s_axis_tx_tdata  (tdata),
    .s_axis_tx_tkeep  (tkeep),
    .s_axis_tx_tlast  (tlast),
    .s_axis_tx_tuser  (tuser),
    .s_axis_tx_tready (tready),
    .frame_valid      (frame_valid),
    .frame_len        (frame_len),
    .frame_err        (frame_err),
    .frame_count      (frame_count),
    .first_beat       (first_beat),
    .ethertype        (ethertype)
`ifdef ETH_TX_SINK_CRC_EN
    ,
    .frame_crc        (frame_crc)
`endif
  );

  always #5 eth_clk = ~eth_clk;

  typedef struct {
    logic [15:0] len;
    logic [3:0]  err;
    logic [31:0] cnt;
    logic [63:0] fb;
    logic [15:0] et;
    logic [31:0] crc;
    bit          chk_crc;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  logic [31:0] exp_count = '0;
  int          first_cyc = 0;
  int          last_xfer = 0;
  int          t_last_a  = 0;
  bit          fv_prev   = 1'b0;

  always @(posedge eth_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard consumer: every frame_valid pulse must match the oldest pushed frame.
  always @(negedge eth_clk) begin
    exp_t e;
    if (frame_valid) begin
      check("fv_not_back_to_back", 64'(fv_prev), 64'd0);
      check("frame_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("frame_len",   64'(frame_len),   64'(e.len));
        check("frame_err",   64'(frame_err),   64'(e.err));
        check("frame_count", 64'(frame_count), 64'(e.cnt));
        check("first_beat",  first_beat,      e.fb);
        check("ethertype",   64'(ethertype),   64'(e.et));
`ifdef ETH_TX_SINK_CRC_EN
        if (e.chk_crc) check("frame_crc", 64'(frame_crc), 64'(e.crc));
`endif
      end
    end
    fv_prev = frame_valid;
  end

  task automatic push_exp(input logic [15:0] len, input logic [3:0] err, input logic [63:0] fb,
                          input logic [15:0] et, input logic [31:0] crc, input bit chk);
    exp_t e;
    exp_count = exp_count + 32'd1;
    e.len = len; e.err = err; e.cnt = exp_count; e.fb = fb; e.et = et; e.crc = crc; e.chk_crc = chk;
    sb.push_back(e);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit l, input bit u);
    int waited;
    bit rdy;
    waited = 0;
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; tuser = u;
    do begin
      @(negedge eth_clk);
      rdy = tready;
      @(posedge eth_clk);
      #1;
      waited++;
    end while (!rdy && waited < 50);
    check("beat_accepted", 64'(rdy), 64'd1);
    last_xfer = cyc;
  endtask

  // Byte j of beat b is seed+8b+j, so bytes 12/13 are seed+12/seed+13.
  task automatic send_frame(input int nbeats, input logic [7:0] seed, input logic [7:0] keep1,
                            input logic [7:0] last_keep, input bit user, input logic [15:0] exp_len,
                            input logic [3:0] exp_err, input logic [15:0] exp_et);
    logic [63:0] fb;
    logic [63:0] d;
    logic [7:0]  k;
    for (int j = 0; j < 8; j++) fb[63-8*j -: 8] = seed + 8'(j);
    push_exp(exp_len, exp_err, fb, exp_et, 32'd0, 1'b0);
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < 8; j++) d[8*j +: 8] = seed + 8'(8*b + j);
      k = (b == nbeats - 1) ? last_keep : ((b == 1) ? keep1 : 8'hFF);
      send_beat(d, k, b == nbeats - 1, user && (b == nbeats - 1));
      if (b == 0) first_cyc = last_xfer;
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    repeat (3) @(posedge eth_clk);
    #1;
    check("rst_tready",      64'(tready),      64'd0);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_frame_len",   64'(frame_len),   64'd0);
    check("rst_frame_err",   64'(frame_err),   64'd0);
    check("rst_first_beat",  first_beat,       64'd0);
    check("rst_ethertype",   64'(ethertype),   64'd0);
    sys_rst = 1'b0;
    check("tready_before_release_edge", 64'(tready), 64'd0);
    @(posedge eth_clk); #1;
    check("tready_after_release", 64'(tready), 64'd1);

    // 60-byte frame: valid at T+1, tready low for two cycles
    send_frame(8, 8'h10, 8'hFF, 8'h0F, 1'b0, 16'd60, 4'b0000, 16'h1C1D);
    tvalid = 1'b0;
    check("fv_at_T1",     64'(frame_valid), 64'd1);
    check("tready_T1",    64'(tready),      64'd0);
    @(posedge eth_clk); #1;
    check("fv_T2",        64'(frame_valid), 64'd0);
    check("tready_T2",    64'(tready),      64'd0);
    @(posedge eth_clk); #1;
    check("tready_T3",    64'(tready),      64'd1);
    check("count_hold",   64'(frame_count), 64'd1);

    // back-to-back frames with tvalid held high
    send_frame(2, 8'h20, 8'hFF, 8'hFF, 1'b0, 16'd16, 4'b0010, 16'h2C2D);
    t_last_a = last_xfer;
    send_frame(8, 8'h40, 8'hFF, 8'hFF, 1'b0, 16'd64, 4'b0000, 16'h4C4D);
    check("b2b_first_beat_delay", 64'(first_cyc - t_last_a), 64'd3);
    tvalid = 1'b0;
    repeat (3) @(posedge eth_clk); #1;
    check("count_after_b2b", 64'(frame_count), 64'd3);

    // tkeep errors: bad non-last keep, and a non-contiguous last keep adding 0 bytes
    send_frame(9, 8'h50, 8'h7F, 8'h05, 1'b0, 16'd64, 4'b0100, 16'h5C5D);
    send_frame(8, 8'h60, 8'hFF, 8'h05, 1'b0, 16'd56, 4'b0110, 16'h6C6D);

    // ethertype presence boundary and single-beat frame
    send_frame(2, 8'h70, 8'hFF, 8'h3F, 1'b0, 16'd14, 4'b0010, 16'h7C7D);
    send_frame(2, 8'h80, 8'hFF, 8'h1F, 1'b0, 16'd13, 4'b0010, 16'h0000);
    send_frame(1, 8'h90, 8'hFF, 8'h0F, 1'b0, 16'd4,  4'b0010, 16'h0000);

    // oversize boundary, abort, and length saturation
    send_frame(190,  8'hA0, 8'hFF, 8'h3F, 1'b0, 16'd1518, 4'b0000, 16'hACAD);
    send_frame(190,  8'hB0, 8'hFF, 8'h7F, 1'b0, 16'd1519, 4'b0001, 16'hBCBD);
    send_frame(200,  8'hC0, 8'hFF, 8'hFF, 1'b1, 16'd1600, 4'b1001, 16'hCCCD);
    send_frame(8192, 8'hD0, 8'hFF, 8'hFF, 1'b0, 16'hFFFF, 4'b0001, 16'hDCDD);

`ifdef ETH_TX_SINK_CRC_EN
    push_exp(16'd9, 4'b0010, 64'h3132333435363738, 16'h0000, 32'hCBF43926, 1'b1);
    send_beat(64'h3837363534333231, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h0000000000000039, 8'h01, 1'b1, 1'b0);
`endif

    tvalid = 1'b0;
    repeat (4) @(posedge eth_clk); #1;
    check("sb_drained_before_reset", 64'(sb.size()), 64'd0);

    // reset in the middle of a frame discards it
    send_beat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h1716151413121110, 8'hFF, 1'b0, 1'b0);
    tvalid  = 1'b0;
    sys_rst = 1'b1;
    @(posedge eth_clk); #1;
    sys_rst   = 1'b0;
    exp_count = '0;
    check("midrst_frame_valid", 64'(frame_valid), 64'd0);
    check("midrst_frame_count", 64'(frame_count), 64'd0);
    check("midrst_frame_len",   64'(frame_len),   64'd0);
    check("midrst_tready_low",  64'(tready),      64'd0);
    @(posedge eth_clk); #1;
    check("midrst_tready_high", 64'(tready),      64'd1);
    check("midrst_no_valid",    64'(frame_valid), 64'd0);

    send_frame(8, 8'hE0, 8'hFF, 8'h0F, 1'b0, 16'd60, 4'b0000, 16'hECED);
    tvalid = 1'b0;
    repeat (4) @(posedge eth_clk); #1;
    check("sb_drained_at_end", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
